// File: rtl/lh_pulse_pkg.sv
// Shared types for the pulse-identification front end.
// Payload field widths, bundled pulse struct, arbiter state enum.
package lh_pulse_pkg;

    localparam int PULSE_WIDTH_W = 16;
    localparam int PULSE_TS_W    = 24;
    localparam int BEAM_W        = 17;

    typedef struct packed {
        logic [PULSE_WIDTH_W-1:0] width;
        logic [PULSE_TS_W-1:0]    ts;
        logic [BEAM_W-1:0]        beam;
    } pulse_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_SEND
    } arb_state_e;

endpackage

// File: rtl/pulse_slot.sv
// One-deep pulse holding register for a single channel.
// Ports: clk_i/rst_ni, cap_i capture strobe, pop_i release strobe,
// data_i payload in, full_o, data_o held payload, drop_o lost-pulse strobe.
module pulse_slot
    import lh_pulse_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   cap_i,
    input  logic   pop_i,
    input  pulse_t data_i,
    output logic   full_o,
    output pulse_t data_o,
    output logic   drop_o
);

    logic   full_q, full_d;
    pulse_t data_q, data_d;

    // A pop frees the slot in the same cycle, so a coincident capture
    // refills it instead of being dropped.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (cap_i && (!full_q || pop_i)) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign drop_o = cap_i && full_q && !pop_i;

endmodule

// File: rtl/pulse_channel_arbiter.sv
// Round-robin arbiter sharing one pulse identifier among NCH channels.
// Ports: Slow_clk/Slow_resetn, ch_en, in_valid, in_width/in_timestamp/
// in_beamWord (flattened, ch0 in LSBs), out_* valid/ready stream with
// channel id, busy, drop_clr, drop_cnt (flattened per-channel counters).
// Macro PULSE_ARB_DROPCNT_EN builds the saturating drop counters;
// without it drop_cnt reads 0 and drop_clr is ignored.
module pulse_channel_arbiter
    import lh_pulse_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic                      Slow_clk,
    input  logic                      Slow_resetn,
    input  logic [NCH-1:0]            ch_en,
    input  logic [NCH-1:0]            in_valid,
    input  logic [NCH*16-1:0]         in_width,
    input  logic [NCH*24-1:0]         in_timestamp,
    input  logic [NCH*17-1:0]         in_beamWord,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ID_W-1:0]           out_id,
    output logic [PULSE_WIDTH_W-1:0]  out_width,
    output logic [PULSE_TS_W-1:0]     out_timestamp,
    output logic [BEAM_W-1:0]         out_beamWord,
    output logic                      busy,
    input  logic                      drop_clr,
    output logic [NCH*CNT_W-1:0]      drop_cnt
);

    arb_state_e      state_q;
    logic [ID_W-1:0] grant_q;
    logic [ID_W-1:0] rr_ptr_q;

    logic [NCH-1:0]  full;
    logic [NCH-1:0]  drop;
    logic [NCH-1:0]  pop;
    pulse_t          slot_data [NCH];

    logic            hs;
    logic            found;
    logic [ID_W-1:0] pick;
    int              idx;

    assign hs = (state_q == ARB_SEND) && out_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_slot
        pulse_t din;
        assign din.width = in_width[i*16 +: 16];
        assign din.ts    = in_timestamp[i*24 +: 24];
        assign din.beam  = in_beamWord[i*17 +: 17];
        assign pop[i]    = hs && (grant_q == ID_W'(i));

        pulse_slot u_slot (
            .clk_i  (Slow_clk),
            .rst_ni (Slow_resetn),
            .cap_i  (in_valid[i] && ch_en[i]),
            .pop_i  (pop[i]),
            .data_i (din),
            .full_o (full[i]),
            .data_o (slot_data[i]),
            .drop_o (drop[i])
        );
    end

    // First full slot at or after rr_ptr, wrapping modulo NCH.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rr_ptr_q) + k) % NCH;
            if (!found && full[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge Slow_clk or negedge Slow_resetn) begin
        if (!Slow_resetn) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (found) begin
                        grant_q <= pick;
                        state_q <= ARB_SEND;
                    end
                end
                ARB_SEND: begin
                    if (out_ready) begin
                        rr_ptr_q <= (grant_q == ID_W'(NCH - 1))
                                    ? '0 : grant_q + 1'b1;
                        state_q  <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Slot payload is frozen while full, so muxing it by the
    // registered grant keeps the stream stable under backpressure.
    assign out_valid     = (state_q == ARB_SEND);
    assign out_id        = grant_q;
    assign out_width     = slot_data[grant_q].width;
    assign out_timestamp = slot_data[grant_q].ts;
    assign out_beamWord  = slot_data[grant_q].beam;
    assign busy          = (|full) || (state_q == ARB_SEND);

`ifdef PULSE_ARB_DROPCNT_EN
    logic [CNT_W-1:0] cnt_q [NCH];

    always_ff @(posedge Slow_clk or negedge Slow_resetn) begin
        if (!Slow_resetn) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (drop_clr) begin
                    cnt_q[i] <= '0;
                end else if (drop[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_cnt
        assign drop_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`else
    logic unused_drop;
    assign unused_drop = ^{drop_clr, drop};
    assign drop_cnt    = '0;
`endif

endmodule
